// File: rtl/mem_burst_master_if.sv
// Bus bundle between the burst master, its command/data peer and the memory pins.
// Every channel transfers on a cycle where valid and ready are both high; valid never waits on ready.
interface mem_burst_master_if #(
  parameter int addr_width = 10,
  parameter int data_width = 64,
  parameter int len_width  = 4
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [addr_width-1:0] cmd_addr;
  logic [len_width-1:0]  cmd_len;
  logic                  wr_valid;
  logic                  wr_ready;
  logic [data_width-1:0] wr_data;
  logic                  rd_valid;
  logic                  rd_ready;
  logic [data_width-1:0] rd_data;
  logic                  rd_last;
  logic                  done;
  logic                  mem_write_en;
  logic [addr_width-1:0] mem_waddr;
  logic [data_width-1:0] mem_wdata;
  logic [addr_width-1:0] mem_raddr;
  logic [data_width-1:0] mem_rdata;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len,
    output cmd_ready,
    input  wr_valid, wr_data,
    output wr_ready,
    output rd_valid, rd_data, rd_last,
    input  rd_ready,
    output done,
    output mem_write_en, mem_waddr, mem_wdata, mem_raddr,
    input  mem_rdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_len,
    input  cmd_ready,
    output wr_valid, wr_data,
    input  wr_ready,
    input  rd_valid, rd_data, rd_last,
    output rd_ready,
    input  done,
    input  mem_write_en, mem_waddr, mem_wdata, mem_raddr,
    output mem_rdata
  );
endinterface

// File: rtl/mem_burst_master.sv
// Burst initiator for a synchronous dual-port memory with 1-cycle read latency;
// read beats pass through a 2-entry skid FIFO so consumer backpressure never drops data.
module mem_burst_master #(
  parameter int addr_width = 10,
  parameter int data_width = 64,
  parameter int len_width  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  mem_burst_master_if.master   bus,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, WRITE = 2'd1, READ = 2'd2} state_t;

  state_t                state, state_nxt;
  logic [addr_width-1:0] addr;
  logic [len_width-1:0]  len;
  logic [len_width:0]    beat_cnt;
  logic [len_width:0]    issue_cnt;
  logic                  inflight;
  logic [data_width-1:0] fifo_mem [2];
  logic                  wptr, rptr;
  logic [1:0]            fifo_cnt;
  logic                  done_q;

  logic cmd_fire, wr_fire, rd_fire, issue, last_beat;

  assign bus.rd_valid  = (fifo_cnt != 2'd0);
  assign bus.rd_data   = fifo_mem[rptr];
  assign bus.rd_last   = bus.rd_valid && (beat_cnt == {1'b0, len});
  assign bus.mem_waddr = addr;
  assign bus.mem_raddr = addr;
  assign bus.done      = done_q;
  assign dbg_state     = state;

  always_comb begin
    state_nxt        = state;
    bus.cmd_ready    = 1'b0;
    bus.wr_ready     = 1'b0;
    bus.mem_write_en = 1'b0;
    bus.mem_wdata    = '0;
    cmd_fire         = 1'b0;
    wr_fire          = 1'b0;
    rd_fire          = 1'b0;
    issue            = 1'b0;
    last_beat        = 1'b0;
    case (state)
      IDLE: begin
        bus.cmd_ready = 1'b1;
        cmd_fire      = bus.cmd_valid;
        if (bus.cmd_valid) state_nxt = bus.cmd_write ? WRITE : READ;
      end
      WRITE: begin
        bus.wr_ready     = 1'b1;
        wr_fire          = bus.wr_valid;
        bus.mem_write_en = wr_fire;
        bus.mem_wdata    = wr_fire ? bus.wr_data : '0;
        last_beat        = wr_fire && (beat_cnt == {1'b0, len});
        if (last_beat) state_nxt = IDLE;
      end
      READ: begin
        rd_fire   = bus.rd_valid && bus.rd_ready;
        // A pop this cycle frees the slot that this issue's data will land in.
        issue     = (({1'b0, fifo_cnt} + {2'b0, inflight}) < (3'd2 + {2'b0, rd_fire}))
                    && (issue_cnt <= {1'b0, len});
        last_beat = rd_fire && bus.rd_last;
        if (last_beat) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      addr      <= '0;
      len       <= '0;
      beat_cnt  <= '0;
      issue_cnt <= '0;
      inflight  <= 1'b0;
      wptr      <= 1'b0;
      rptr      <= 1'b0;
      fifo_cnt  <= 2'd0;
      done_q    <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_q <= last_beat;
      if (cmd_fire) begin
        addr      <= bus.cmd_addr;
        len       <= bus.cmd_len;
        beat_cnt  <= '0;
        issue_cnt <= '0;
        inflight  <= 1'b0;
        wptr      <= 1'b0;
        rptr      <= 1'b0;
        fifo_cnt  <= 2'd0;
      end else begin
        if (wr_fire || issue) addr <= addr + 1'b1;
        if (wr_fire || rd_fire) beat_cnt <= beat_cnt + 1'b1;
        if (issue) issue_cnt <= issue_cnt + 1'b1;
        inflight <= issue;
        if (inflight) wptr <= ~wptr;
        if (rd_fire) rptr <= ~rptr;
        fifo_cnt <= fifo_cnt + {1'b0, inflight} - {1'b0, rd_fire};
      end
    end
  end

  // Storage only; occupancy and pointers carry the reset.
  always_ff @(posedge clk) begin
    if (inflight) fifo_mem[wptr] <= bus.mem_rdata;
  end

endmodule

// File: tb/tb_mem_burst_master.sv
// Bench for mem_burst_master: behavioural memory, shadow memory model, read-beat scoreboard.
module tb_mem_burst_master;
  localparam int AW = 10;
  localparam int DW = 64;
  localparam int LW = 4;

  logic clk;
  logic rst;
  logic [1:0] dbg_state;

  mem_burst_master_if #(.addr_width(AW), .data_width(DW), .len_width(LW)) bus ();

  mem_burst_master #(.addr_width(AW), .data_width(DW), .len_width(LW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.master),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [DW-1:0] mem     [1024];
  logic [DW-1:0] ref_mem [1024];
  logic [DW-1:0] exp_q [$];
  logic          last_q [$];
  logic [5:0]    pat6 = 6'b101001;

  always @(posedge clk) begin
    if (bus.mem_write_en) mem[bus.mem_waddr] <= bus.mem_wdata;
    bus.mem_rdata <= mem[bus.mem_raddr];
  end

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard: pop on every accepted read beat
  always @(negedge clk) begin
    if (!rst && bus.rd_valid && bus.rd_ready) begin
      if (exp_q.size() == 0) begin
        check("rd_unexpected_beat", 64'd1, 64'd0);
      end else begin
        check("rd_data", bus.rd_data, exp_q.pop_front());
        check("rd_last", {63'd0, bus.rd_last}, {63'd0, last_q.pop_front()});
      end
    end
    if (!rst && (bus.mem_write_en || bus.wr_valid))
      check("mem_write_en_on_handshake", {63'd0, bus.mem_write_en}, {63'd0, bus.wr_valid});
  end

  function automatic logic ready_pat(input int mode, input int c);
    case (mode)
      0:       return 1'b1;
      1:       return pat6[5 - (c % 6)];
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Offers a command; returns #1 after the accepting edge (first cycle of the burst).
  task automatic send_cmd(input logic wr, input logic [AW-1:0] a, input logic [LW-1:0] l);
    int c;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1; bus.cmd_write = wr; bus.cmd_addr = a; bus.cmd_len = l;
    for (c = 0; c < 50; c++) begin
      @(negedge clk);
      if (bus.cmd_ready) break;
      @(posedge clk); #1;
    end
    if (c == 50) check("cmd_accept_timeout", 64'd1, 64'd0);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic push_read_exp(input logic [AW-1:0] a, input logic [LW-1:0] l);
    logic [AW-1:0] idx;
    for (int i = 0; i <= int'(l); i++) begin
      idx = a + AW'(i);
      exp_q.push_back(ref_mem[idx]);
      last_q.push_back(i == int'(l));
    end
  endtask

  task automatic run_read(input logic [AW-1:0] a, input logic [LW-1:0] l, input int mode,
                          output int beats, output int first_cyc, output logic [DW-1:0] first_data,
                          output int done_cyc);
    logic cmd_ready_mid;
    beats = 0; first_cyc = -1; first_data = '0; done_cyc = -1; cmd_ready_mid = 1'b0;
    push_read_exp(a, l);
    send_cmd(1'b0, a, l);
    for (int c = 0; c < 200; c++) begin
      bus.rd_ready = ready_pat(mode, c);
      @(negedge clk);
      if (c == 0) check("rd_first_raddr", {54'd0, bus.mem_raddr}, {54'd0, a});
      if (bus.done) begin
        done_cyc = c;
        break;
      end
      if (bus.cmd_ready) cmd_ready_mid = 1'b1;
      if (bus.rd_valid && first_cyc < 0) begin
        first_cyc  = c;
        first_data = bus.rd_data;
      end
      if (bus.rd_valid && bus.rd_ready) beats++;
      @(posedge clk); #1;
    end
    if (done_cyc < 0) check("rd_done_timeout", 64'd1, 64'd0);
    check("cmd_ready_low_in_read", {63'd0, cmd_ready_mid}, 64'd0);
    @(posedge clk); #1;
    bus.rd_ready = 1'b0;
    @(negedge clk);
    check("done_single_pulse", {63'd0, bus.done}, 64'd0);
  endtask

  task automatic run_write(input logic [AW-1:0] a, input logic [LW-1:0] l,
                           input logic [DW-1:0] base, input int gap_cycle);
    int i;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    i = 0;
    send_cmd(1'b1, a, l);
    for (int c = 0; c < 100 && i <= int'(l); c++) begin
      wd = base + DW'(i * 17);
      wa = a + AW'(i);
      bus.wr_valid = (c != gap_cycle);
      bus.wr_data  = wd;
      @(negedge clk);
      if (bus.wr_valid) begin
        check("wr_ready", {63'd0, bus.wr_ready}, 64'd1);
        check("mem_waddr", {54'd0, bus.mem_waddr}, {54'd0, wa});
        check("mem_wdata", bus.mem_wdata, wd);
        if (bus.wr_ready) begin
          ref_mem[wa] = wd;
          i++;
        end
      end
      @(posedge clk); #1;
    end
    if (i <= int'(l)) check("wr_beat_timeout", 64'd1, 64'd0);
    bus.wr_valid = 1'b0;
    @(negedge clk);
    check("wr_done", {63'd0, bus.done}, 64'd1);
    check("wr_ready_after_done", {63'd0, bus.wr_ready}, 64'd0);
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [AW-1:0] addr;
    logic [LW-1:0] len;
    int            mode;
    logic [DW-1:0] exp_first;
    int            exp_beats;
    int            exp_lat;
  } rvec_t;

  rvec_t vecs [6];

  initial begin
    int beats, first_cyc, done_cyc, c;
    logic [DW-1:0] first_data;
    logic seen_done;

    for (int k = 0; k < 1024; k++) begin
      mem[k]     = DW'(k + 1);
      ref_mem[k] = DW'(k + 1);
    end
    vecs[0] = '{10'd5,    4'd3,  0, 64'd6,    4,  2};
    vecs[1] = '{10'd2,    4'd7,  1, 64'd3,    8,  2};
    vecs[2] = '{10'd1022, 4'd3,  0, 64'd1023, 4,  2};
    vecs[3] = '{10'd0,    4'd15, 2, 64'd1,    16, 2};
    vecs[4] = '{10'd1023, 4'd0,  0, 64'd1024, 1,  2};
    vecs[5] = '{10'd100,  4'd15, 0, 64'd101,  16, 2};

    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0; bus.cmd_len = '0;
    bus.wr_valid = 1'b0; bus.wr_data = '0; bus.rd_ready = 1'b0;
    do_reset();

    // reset state
    @(negedge clk);
    check("rst_cmd_ready",    {63'd0, bus.cmd_ready},    64'd1);
    check("rst_wr_ready",     {63'd0, bus.wr_ready},     64'd0);
    check("rst_rd_valid",     {63'd0, bus.rd_valid},     64'd0);
    check("rst_rd_last",      {63'd0, bus.rd_last},      64'd0);
    check("rst_done",         {63'd0, bus.done},         64'd0);
    check("rst_mem_write_en", {63'd0, bus.mem_write_en}, 64'd0);
    check("rst_mem_waddr",    {54'd0, bus.mem_waddr},    64'd0);
    check("rst_mem_raddr",    {54'd0, bus.mem_raddr},    64'd0);
    check("rst_mem_wdata",    bus.mem_wdata,             64'd0);

    // table-driven read bursts
    for (int v = 0; v < 6; v++) begin
      run_read(vecs[v].addr, vecs[v].len, vecs[v].mode, beats, first_cyc, first_data, done_cyc);
      check("tbl_beats", 64'(beats), 64'(vecs[v].exp_beats));
      check("tbl_first_data", first_data, vecs[v].exp_first);
      check("tbl_first_latency", 64'(first_cyc), 64'(vecs[v].exp_lat));
      if (vecs[v].mode == 0)
        check("tbl_stream_done_cycle", 64'(done_cyc), 64'(vecs[v].exp_lat + vecs[v].exp_beats));
    end
    check("sb_drained_tbl", 64'(exp_q.size()), 64'd0);

    // write with a one-cycle wr_valid gap, then read it back
    run_write(10'h10, 4'd1, 64'hAA, 1);
    check("ref_after_write", ref_mem[10'h11], 64'hBB);
    run_read(10'h10, 4'd1, 0, beats, first_cyc, first_data, done_cyc);
    check("wb_first", first_data, 64'hAA);
    check("wb_beats", 64'(beats), 64'd2);

    // random-length write burst read back with random backpressure
    run_write(10'h200, 4'($urandom_range(0, 15)), 64'h1234_0000, int'($urandom_range(0, 3)));
    run_read(10'h200, 4'd15, 2, beats, first_cyc, first_data, done_cyc);
    check("rand_rb_beats", 64'(beats), 64'd16);

    // reset during beat 2 of a len=7 read
    push_read_exp(10'd0, 4'd7);
    send_cmd(1'b0, 10'd0, 4'd7);
    bus.rd_ready = 1'b1;
    beats = 0;
    for (c = 0; c < 50; c++) begin
      @(negedge clk);
      if (bus.rd_valid && bus.rd_ready) beats++;
      @(posedge clk); #1;
      if (beats == 2) break;
    end
    check("midrst_reached_beat2", 64'(beats), 64'd2);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.rd_ready = 1'b0;
    @(negedge clk);
    check("midrst_rd_valid",  {63'd0, bus.rd_valid},  64'd0);
    check("midrst_cmd_ready", {63'd0, bus.cmd_ready}, 64'd1);
    check("midrst_done",      {63'd0, bus.done},      64'd0);
    exp_q.delete();
    last_q.delete();
    run_read(10'd0, 4'd0, 0, beats, first_cyc, first_data, done_cyc);
    check("midrst_new_read", first_data, 64'd1);
    check("midrst_new_beats", 64'(beats), 64'd1);

    // back-to-back: cmd_valid held across two commands
    push_read_exp(10'd5, 4'd3);
    push_read_exp(10'd20, 4'd0);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = 10'd5; bus.cmd_len = 4'd3;
    bus.rd_ready = 1'b1;
    @(negedge clk);
    check("b2b_first_accept", {63'd0, bus.cmd_ready}, 64'd1);
    @(posedge clk); #1;
    bus.cmd_addr = 10'd20; bus.cmd_len = 4'd0;
    seen_done = 1'b0;
    for (c = 0; c < 50; c++) begin
      @(negedge clk);
      if (bus.done) seen_done = 1'b1;
      if (bus.cmd_ready) break;
      @(posedge clk); #1;
    end
    check("b2b_second_after_done", {63'd0, seen_done}, 64'd1);
    check("b2b_first_burst_cycles", 64'(c), 64'd6);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    seen_done = 1'b0;
    for (c = 0; c < 50; c++) begin
      @(negedge clk);
      if (bus.done) begin
        seen_done = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    check("b2b_second_done", {63'd0, seen_done}, 64'd1);
    bus.rd_ready = 1'b0;
    check("sb_drained_end", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion before %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
